// File: rtl/msdap_pkg.sv
// msdap_pkg: shared definitions for the MSDAP output serializer.
//   MSDAP_WORD_W : width of one channel result word (bits per frame)
//   MSDAP_CNT_W  : width of the bit-position counter (2**MSDAP_CNT_W >= MSDAP_WORD_W)
//   tx_state_t   : serializer FSM state encoding
package msdap_pkg;

  localparam int MSDAP_WORD_W = 40;
  localparam int MSDAP_CNT_W  = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

endpackage

// File: rtl/msdap_piso_ch.sv
// msdap_piso_ch: one channel of the output serializer. A WIDTH-bit
// parallel-load shift register clocked on the falling edge of sclk.
//   sclk    : serial clock (state updates on negedge)
//   reset_n : asynchronous active-low reset, clears the register
//   load    : capture din (has priority over shift)
//   shift   : shift left by one, inserting 0 at the LSB
//   din     : parallel word to load
//   msb     : current serial bit (register MSB)
module msdap_piso_ch #(
  parameter int WIDTH = 40
) (
  input  logic             sclk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] shreg;

  // Zero-fill on shift means the register is all zeros once a full frame
  // has been shifted out, so msb is 0 whenever the transmitter is idle.
  always_ff @(negedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/msdap_serial_tx.sv
// msdap_serial_tx: stereo output serializer. Takes one WIDTH-bit word per
// channel and shifts both out MSB-first, one bit per sclk period, with
// frame_sync marking the first bit of each frame. All state changes on the
// falling edge of sclk so outputs are stable at the rising edge.
//
// Optional feature macro: TX_HOLD_BUF_EN adds a one-entry holding buffer
// so a following word pair can be queued during a frame and frames run
// back-to-back with no idle period.
//
// Ports:
//   sclk       : serial clock, state updates on negedge
//   reset_n    : asynchronous active-low reset
//   in_l/in_r  : left/right parallel result words
//   in_valid   : in_l/in_r hold a word pair to send
//   in_ready   : block can accept a word pair on the next negedge
//   out_l/out_r: left/right serial data
//   frame_sync : high during the bit period carrying bit WIDTH-1
//   busy       : frame in progress
//   state_dbg  : current FSM state, for observation
//
// Handshake: a word pair transfers on a falling sclk edge where
// in_valid && in_ready. in_ready never depends on in_valid; the source may
// drop in_valid without a transfer. in_l/in_r are sampled only on the
// transfer edge.
module msdap_serial_tx
  import msdap_pkg::*;
#(
  parameter int WIDTH = MSDAP_WORD_W,
  parameter int CNT_W = MSDAP_CNT_W
) (
  input  logic             sclk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_l,
  input  logic [WIDTH-1:0] in_r,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_l,
  output logic             out_r,
  output logic             frame_sync,
  output logic             busy,
  output tx_state_t        state_dbg
);

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             fs_q;
  logic             accept;
  logic             last_bit;
  logic             load;
  logic             shift;
  logic [WIDTH-1:0] load_l;
  logic [WIDTH-1:0] load_r;

  assign accept   = in_valid && in_ready;
  // Edge on which the final bit of the frame stops being presented.
  assign last_bit = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));

`ifdef TX_HOLD_BUF_EN
  logic [WIDTH-1:0] hold_l;
  logic [WIDTH-1:0] hold_r;
  logic             hold_full;
  logic             hold_wr;

  assign in_ready = !hold_full;
  // A queued pair has priority at the frame boundary; with the buffer empty
  // a pair arriving on that same edge goes straight to the shift registers.
  assign load     = ((state == IDLE) && accept) || (last_bit && (hold_full || accept));
  assign load_l   = (last_bit && hold_full) ? hold_l : in_l;
  assign load_r   = (last_bit && hold_full) ? hold_r : in_r;
  // Mid-frame transfers park in the buffer.
  assign hold_wr  = accept && (state == SHIFT) && !last_bit;

  always_ff @(negedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      hold_l    <= '0;
      hold_r    <= '0;
      hold_full <= 1'b0;
    end else if (hold_wr) begin
      hold_l    <= in_l;
      hold_r    <= in_r;
      hold_full <= 1'b1;
    end else if (last_bit && hold_full) begin
      hold_full <= 1'b0;
    end
  end
`else
  // Without a buffer the next pair is only taken once the line is idle,
  // which leaves at least one idle bit period between frames.
  assign in_ready = (state == IDLE);
  assign load     = (state == IDLE) && accept;
  assign load_l   = in_l;
  assign load_r   = in_r;
`endif

  assign shift = (state == SHIFT) && !load;

  always_ff @(negedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      fs_q  <= 1'b0;
    end else if (load) begin
      state <= SHIFT;
      cnt   <= '0;
      fs_q  <= 1'b1;
    end else if (state == SHIFT) begin
      fs_q <= 1'b0;
      if (last_bit) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  msdap_piso_ch #(.WIDTH(WIDTH)) u_ch_l (
    .sclk    (sclk),
    .reset_n (reset_n),
    .load    (load),
    .shift   (shift),
    .din     (load_l),
    .msb     (out_l)
  );

  msdap_piso_ch #(.WIDTH(WIDTH)) u_ch_r (
    .sclk    (sclk),
    .reset_n (reset_n),
    .load    (load),
    .shift   (shift),
    .din     (load_r),
    .msb     (out_r)
  );

  assign frame_sync = fs_q;
  assign busy       = (state == SHIFT);
  assign state_dbg  = state;

endmodule

// File: tb/tb_msdap_serial_tx.sv
// tb_msdap_serial_tx: directed bench for msdap_serial_tx. Inputs are driven
// on the rising sclk edge and outputs sampled there; the DUT acts on the
// falling edge. Buffered-mode scenarios are built when TX_HOLD_BUF_EN is set.
module tb_msdap_serial_tx;
  import msdap_pkg::*;

  localparam int W = 40;

  logic         sclk;
  logic         reset_n;
  logic [W-1:0] in_l;
  logic [W-1:0] in_r;
  logic         in_valid;
  logic         in_ready;
  logic         out_l;
  logic         out_r;
  logic         frame_sync;
  logic         busy;
  tx_state_t    state_dbg;

  int checks;
  int failures;

  logic [W-1:0] src_l [0:3];
  logic [W-1:0] src_r [0:3];
  logic         rec_l    [0:199];
  logic         rec_r    [0:199];
  logic         rec_fs   [0:199];
  logic         rec_busy [0:199];
  logic         rec_rdy  [0:199];

  msdap_serial_tx dut (
    .sclk       (sclk),
    .reset_n    (reset_n),
    .in_l       (in_l),
    .in_r       (in_r),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_l      (out_l),
    .out_r      (out_r),
    .frame_sync (frame_sync),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver ----------------
  // Offers src pairs in order and records outputs each rising edge
  // (sample c). Pair 0 is offered at sample 0; later pairs only from
  // sample rel_c on. At sample glitch_c (when nothing is offered) the data
  // inputs are inverted without in_valid.
  task automatic run_stream(input int npairs, input int rel_c,
                            input int glitch_c, input int ncycles);
    int   idx;
    logic pend;
    idx  = 0;
    pend = 1'b0;
    for (int c = 0; c < ncycles; c++) begin
      @(posedge sclk);
      if (pend) idx++;
      rec_l[c]    = out_l;
      rec_r[c]    = out_r;
      rec_fs[c]   = frame_sync;
      rec_busy[c] = busy;
      rec_rdy[c]  = in_ready;
      if (idx < npairs && (idx == 0 || c >= rel_c)) begin
        in_valid = 1'b1;
        in_l     = src_l[idx];
        in_r     = src_r[idx];
      end else begin
        in_valid = 1'b0;
        if (c == glitch_c) begin
          in_l = ~in_l;
          in_r = ~in_r;
        end
      end
      pend = in_valid && in_ready;
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] word_l(input int s);
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < W; k++) w = {w[W-2:0], rec_l[s+k]};
    return w;
  endfunction

  function automatic logic [W-1:0] word_r(input int s);
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < W; k++) w = {w[W-2:0], rec_r[s+k]};
    return w;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(posedge sclk);
    checks++; if (out_l !== 1'b0) begin failures++; $display("FAIL rst_out_l: got %b expected 0", out_l); end
    checks++; if (out_r !== 1'b0) begin failures++; $display("FAIL rst_out_r: got %b expected 0", out_r); end
    checks++; if (frame_sync !== 1'b0) begin failures++; $display("FAIL rst_fs: got %b expected 0", frame_sync); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b expected 1", in_ready); end
    checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL rst_state: got %0d expected %0d", state_dbg, IDLE); end
    reset_n = 1'b1;
    repeat (2) @(posedge sclk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_rst_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready: got %b expected 1", in_ready); end

    // Abort a frame at bit 17 (sample 18).
    src_l[0] = 40'hFF_FFFF_FFFF;
    src_r[0] = 40'hFF_FFFF_FFFF;
    run_stream(1, 1, -1, 19);
    checks++; if (rec_l[18] !== 1'b1 || rec_busy[18] !== 1'b1) begin
      failures++; $display("FAIL abort_pre: got l=%b busy=%b expected 1 1", rec_l[18], rec_busy[18]);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({out_l, out_r, frame_sync, busy} !== 4'b0000) begin
      failures++; $display("FAIL abort_outputs: got %b expected 0000", {out_l, out_r, frame_sync, busy});
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b expected 1", in_ready); end
    @(posedge sclk);
    reset_n = 1'b1;

    src_l[0] = 40'h12_3456_789A;
    src_r[0] = 40'hFE_DCBA_9876;
    run_stream(1, 1, -1, 42);
    checks++; if (rec_busy[0] !== 1'b0 || rec_l[0] !== 1'b0) begin
      failures++; $display("FAIL fresh_idle: got busy=%b l=%b expected 0 0", rec_busy[0], rec_l[0]);
    end
    checks++; if (rec_fs[1] !== 1'b1) begin failures++; $display("FAIL fresh_fs: got %b expected 1", rec_fs[1]); end
    checks++; if (word_l(1) !== 40'h12_3456_789A) begin failures++; $display("FAIL fresh_word_l: got %h expected 123456789a", word_l(1)); end
    checks++; if (word_r(1) !== 40'hFE_DCBA_9876) begin failures++; $display("FAIL fresh_word_r: got %h expected fedcba9876", word_r(1)); end
  endtask

  task automatic test_single_frame();
    logic el, er;
    src_l[0] = 40'h80_0000_0001;
    src_r[0] = 40'h55_5555_5555;
    run_stream(1, 1, -1, 43);
    for (int k = 0; k < W; k++) begin
      el = (k == 0 || k == W - 1);
      er = (k % 2 == 1);
      checks++; if (rec_l[k+1] !== el) begin failures++; $display("FAIL single_out_l bit %0d: got %b expected %b", k, rec_l[k+1], el); end
      checks++; if (rec_r[k+1] !== er) begin failures++; $display("FAIL single_out_r bit %0d: got %b expected %b", k, rec_r[k+1], er); end
      checks++; if (rec_fs[k+1] !== (k == 0)) begin failures++; $display("FAIL single_fs bit %0d: got %b expected %b", k, rec_fs[k+1], (k == 0)); end
      checks++; if (rec_busy[k+1] !== 1'b1) begin failures++; $display("FAIL single_busy bit %0d: got %b expected 1", k, rec_busy[k+1]); end
    end
    checks++; if ({rec_busy[41], rec_fs[41], rec_l[41], rec_r[41]} !== 4'b0000) begin
      failures++; $display("FAIL single_after: got %b expected 0000", {rec_busy[41], rec_fs[41], rec_l[41], rec_r[41]});
    end
    checks++; if (rec_rdy[41] !== 1'b1) begin failures++; $display("FAIL single_ready_after: got %b expected 1", rec_rdy[41]); end
  endtask

  task automatic test_input_stability();
    src_l[0] = 40'hC3_5A96_0F1E;
    src_r[0] = 40'h0F_F00F_F00F;
    run_stream(1, 1, 20, 43);
    checks++; if (word_l(1) !== 40'hC3_5A96_0F1E) begin failures++; $display("FAIL stable_word_l: got %h expected c35a960f1e", word_l(1)); end
    checks++; if (word_r(1) !== 40'h0F_F00F_F00F) begin failures++; $display("FAIL stable_word_r: got %h expected 0ff00ff00f", word_r(1)); end
    checks++; if (rec_busy[41] !== 1'b0) begin failures++; $display("FAIL stable_end: got %b expected 0", rec_busy[41]); end
  endtask

`ifndef TX_HOLD_BUF_EN
  task automatic test_back_pressure();
    int rdy_hi;
    src_l[0] = 40'h01_2345_6789; src_r[0] = 40'hAB_CDEF_0123;
    src_l[1] = 40'hF0_0000_000F; src_r[1] = 40'h00_FFFF_FF00;
    src_l[2] = 40'h5A_5A5A_5A5A; src_r[2] = 40'hA5_A5A5_A5A5;
    run_stream(3, 1, -1, 125);
    // Frames at samples 1, 42, 83 with idle samples 41 and 82.
    checks++; if (word_l(1) !== 40'h01_2345_6789 || word_r(1) !== 40'hAB_CDEF_0123) begin
      failures++; $display("FAIL bp_word0: got %h/%h expected 0123456789/abcdef0123", word_l(1), word_r(1));
    end
    checks++; if (word_l(42) !== 40'hF0_0000_000F || word_r(42) !== 40'h00_FFFF_FF00) begin
      failures++; $display("FAIL bp_word1: got %h/%h expected f00000000f/00ffffff00", word_l(42), word_r(42));
    end
    checks++; if (word_l(83) !== 40'h5A_5A5A_5A5A || word_r(83) !== 40'hA5_A5A5_A5A5) begin
      failures++; $display("FAIL bp_word2: got %h/%h expected 5a5a5a5a5a/a5a5a5a5a5", word_l(83), word_r(83));
    end
    checks++; if ({rec_fs[1], rec_fs[42], rec_fs[83]} !== 3'b111) begin
      failures++; $display("FAIL bp_fs: got %b expected 111", {rec_fs[1], rec_fs[42], rec_fs[83]});
    end
    checks++; if ({rec_busy[41], rec_busy[82], rec_busy[123]} !== 3'b000) begin
      failures++; $display("FAIL bp_gap_busy: got %b expected 000", {rec_busy[41], rec_busy[82], rec_busy[123]});
    end
    checks++; if ({rec_busy[40], rec_busy[42], rec_busy[81], rec_busy[83]} !== 4'b1111) begin
      failures++; $display("FAIL bp_frame_edges: got %b expected 1111", {rec_busy[40], rec_busy[42], rec_busy[81], rec_busy[83]});
    end
    rdy_hi = 0;
    for (int c = 0; c < 125; c++) if (rec_busy[c] && rec_rdy[c]) rdy_hi++;
    checks++; if (rdy_hi !== 0) begin failures++; $display("FAIL bp_ready_in_frame: got %0d expected 0", rdy_hi); end
    checks++; if ({rec_rdy[41], rec_rdy[82]} !== 2'b11) begin
      failures++; $display("FAIL bp_ready_gap: got %b expected 11", {rec_rdy[41], rec_rdy[82]});
    end
  endtask
`else
  task automatic test_gapless();
    int nbusy;
    int nfs;
    src_l[0] = 40'h01_2345_6789; src_r[0] = 40'hAB_CDEF_0123;
    src_l[1] = 40'hF0_0000_000F; src_r[1] = 40'h00_FFFF_FF00;
    src_l[2] = 40'h5A_5A5A_5A5A; src_r[2] = 40'hA5_A5A5_A5A5;
    run_stream(3, 1, -1, 123);
    nbusy = 0;
    nfs   = 0;
    for (int c = 1; c <= 120; c++) if (rec_busy[c]) nbusy++;
    for (int c = 0; c < 123; c++) if (rec_fs[c]) nfs++;
    checks++; if (nbusy !== 120) begin failures++; $display("FAIL gl_busy_count: got %0d expected 120", nbusy); end
    checks++; if (rec_busy[121] !== 1'b0) begin failures++; $display("FAIL gl_end: got %b expected 0", rec_busy[121]); end
    checks++; if ({rec_fs[1], rec_fs[41], rec_fs[81]} !== 3'b111 || nfs !== 3) begin
      failures++; $display("FAIL gl_fs: got %b count %0d expected 111 count 3", {rec_fs[1], rec_fs[41], rec_fs[81]}, nfs);
    end
    checks++; if (word_l(1) !== 40'h01_2345_6789 || word_r(1) !== 40'hAB_CDEF_0123) begin
      failures++; $display("FAIL gl_word0: got %h/%h expected 0123456789/abcdef0123", word_l(1), word_r(1));
    end
    checks++; if (word_l(41) !== 40'hF0_0000_000F || word_r(41) !== 40'h00_FFFF_FF00) begin
      failures++; $display("FAIL gl_word1: got %h/%h expected f00000000f/00ffffff00", word_l(41), word_r(41));
    end
    checks++; if (word_l(81) !== 40'h5A_5A5A_5A5A || word_r(81) !== 40'hA5_A5A5_A5A5) begin
      failures++; $display("FAIL gl_word2: got %h/%h expected 5a5a5a5a5a/a5a5a5a5a5", word_l(81), word_r(81));
    end
    checks++; if ({rec_rdy[1], rec_rdy[2], rec_rdy[40], rec_rdy[41], rec_rdy[42]} !== 5'b10010) begin
      failures++; $display("FAIL gl_ready: got %b expected 10010",
                           {rec_rdy[1], rec_rdy[2], rec_rdy[40], rec_rdy[41], rec_rdy[42]});
    end
  endtask

  task automatic test_same_edge_refill();
    src_l[0] = 40'h00_0000_0003; src_r[0] = 40'hC0_0000_0000;
    src_l[1] = 40'h96_0000_0069; src_r[1] = 40'h3C_C33C_C33C;
    // Second pair offered first at sample 40, i.e. for the last-bit edge.
    run_stream(2, 40, -1, 83);
    checks++; if (rec_rdy[40] !== 1'b1 || rec_busy[40] !== 1'b1) begin
      failures++; $display("FAIL refill_pre: got rdy=%b busy=%b expected 1 1", rec_rdy[40], rec_busy[40]);
    end
    checks++; if (rec_busy[41] !== 1'b1 || rec_fs[41] !== 1'b1) begin
      failures++; $display("FAIL refill_nogap: got busy=%b fs=%b expected 1 1", rec_busy[41], rec_fs[41]);
    end
    checks++; if (word_l(1) !== 40'h00_0000_0003 || word_r(1) !== 40'hC0_0000_0000) begin
      failures++; $display("FAIL refill_word0: got %h/%h expected 0000000003/c000000000", word_l(1), word_r(1));
    end
    checks++; if (word_l(41) !== 40'h96_0000_0069 || word_r(41) !== 40'h3C_C33C_C33C) begin
      failures++; $display("FAIL refill_word1: got %h/%h expected 9600000069/3cc33cc33c", word_l(41), word_r(41));
    end
    checks++; if (rec_busy[81] !== 1'b0) begin failures++; $display("FAIL refill_end: got %b expected 0", rec_busy[81]); end
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_l     = '0;
    in_r     = '0;
    repeat (3) @(posedge sclk);
    test_reset();
    repeat (2) @(posedge sclk);
    test_single_frame();
    repeat (2) @(posedge sclk);
    test_input_stability();
    repeat (2) @(posedge sclk);
`ifndef TX_HOLD_BUF_EN
    test_back_pressure();
`else
    test_gapless();
    repeat (2) @(posedge sclk);
    test_same_edge_refill();
`endif
    repeat (2) @(posedge sclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
